// File: rtl/mem_lsu_stage.sv
// Memory-stage load/store unit: one req/ack data-bus transaction per load/store, stalling the pipe until done.
// Optional misaligned-access trap: define LSU_MISALIGN_CHK_EN.
module mem_lsu_stage #(
    parameter  int unsigned TIMEOUT = 16,
    parameter  int unsigned TO_W    = 16,
    localparam int unsigned XLEN    = 32,
    localparam int unsigned BE_W    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_rd,
    input  logic            mem_wr,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            stall,
    output logic [XLEN-1:0] dm_out,
    output logic            bus_err,
    output logic            misalign,
    output logic            dbus_req,
    output logic            dbus_we,
    output logic [XLEN-1:0] dbus_addr,
    output logic [BE_W-1:0] dbus_be,
    output logic [XLEN-1:0] dbus_wdata,
    input  logic            dbus_ack,
    input  logic [XLEN-1:0] dbus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              kill_q, kill_d;
    logic [1:0]        ofs_q, ofs_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   dm_q, dm_d;
    logic              err_q, err_d;

    logic              access_c;
    logic              kill_c;
    logic [1:0]        ofs_c;
    logic [BE_W-1:0]   lane_be_c;
    logic [XLEN-1:0]   lane_wdata_c;
    logic              unused_func3;

    // Signedness of a load is resolved downstream, so func3[2] is not needed here.
    assign unused_func3 = func3[2];
    assign access_c     = mem_rd | mem_wr;
    assign ofs_c        = alu_out[1:0];
    assign kill_c       = kill_q | flush;

`ifdef LSU_MISALIGN_CHK_EN
    logic mis_q, mis_d;
    logic misaligned_c;

    assign misaligned_c = ((func3[1:0] == 2'b01) && alu_out[0]) ||
                          (func3[1] && (ofs_c != 2'b00));
`endif

    // Byte-lane enables and store-data replication for the addressed width.
    always_comb begin : lane_gen
        lane_be_c    = 4'b1111;
        lane_wdata_c = rs2_data;
        case (func3[1:0])
            2'b00: begin
                lane_be_c    = 4'b0001 << ofs_c;
                lane_wdata_c = {4{rs2_data[7:0]}};
            end
            2'b01: begin
                lane_be_c    = 4'b0011 << {ofs_c[1], 1'b0};
                lane_wdata_c = {2{rs2_data[15:0]}};
            end
            default: begin
                lane_be_c    = 4'b1111;
                lane_wdata_c = rs2_data;
            end
        endcase
    end

    always_comb begin : next_state
        state_d = state_q;
        cnt_d   = cnt_q;
        kill_d  = kill_q;
        ofs_d   = ofs_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        dm_d    = dm_q;
        err_d   = 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
        mis_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (access_c && !flush) begin
`ifdef LSU_MISALIGN_CHK_EN
                    if (misaligned_c) begin
                        mis_d   = 1'b1;
                        dm_d    = '0;
                        state_d = S_DONE;
                    end else
`endif
                    begin
                        req_d   = 1'b1;
                        we_d    = mem_wr;
                        addr_d  = {alu_out[XLEN-1:2], 2'b00};
                        be_d    = lane_be_c;
                        wdata_d = lane_wdata_c;
                        ofs_d   = ofs_c;
                        cnt_d   = '0;
                        kill_d  = 1'b0;
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                // A flush cannot abandon the bus cycle; it only discards the result.
                kill_d = kill_c;
                if (dbus_ack) begin
                    req_d = 1'b0;
                    if (!kill_c && !we_q) begin
                        dm_d = dbus_rdata >> {ofs_q, 3'b000};
                    end
                    state_d = kill_c ? S_IDLE : S_DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_W'(TIMEOUT - 1))) begin
                    req_d = 1'b0;
                    err_d = 1'b1;
                    if (!kill_c) begin
                        dm_d = '0;
                    end
                    state_d = kill_c ? S_IDLE : S_DONE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin : state_reg
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            kill_q  <= 1'b0;
            ofs_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            dm_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kill_q  <= kill_d;
            ofs_q   <= ofs_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            dm_q    <= dm_d;
            err_q   <= err_d;
        end
    end

`ifdef LSU_MISALIGN_CHK_EN
    always_ff @(posedge clk or posedge rst) begin : mis_reg
        if (rst) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign misalign = mis_q;
`else
    assign misalign = 1'b0;
`endif

    // Stall is combinational so the upstream freeze takes effect in the request cycle.
    assign stall = !rst && (((state_q == S_IDLE) && access_c && !flush) ||
                            (state_q == S_BUSY));

    assign dm_out     = dm_q;
    assign bus_err    = err_q;
    assign dbus_req   = req_q;
    assign dbus_we    = we_q;
    assign dbus_addr  = addr_q;
    assign dbus_be    = be_q;
    assign dbus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Self-checking bench for mem_lsu_stage: scoreboard of expected bus fields and load results.
module tb_mem_lsu_stage;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        rst;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  func3;
    logic [31:0] alu_out;
    logic [31:0] rs2_data;
    logic        flush;
    logic        stall;
    logic [31:0] dm_out;
    logic        bus_err;
    logic        misalign;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    mem_lsu_stage #(.TIMEOUT(TO), .TO_W(16)) dut (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .func3(func3),
        .alu_out(alu_out), .rs2_data(rs2_data), .flush(flush), .stall(stall),
        .dm_out(dm_out), .bus_err(bus_err), .misalign(misalign), .dbus_req(dbus_req),
        .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
        .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_wdata;
        logic [31:0] dm;
        int          stalls;
        int          reqs;
        int          errs;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_dm;

    logic        obs_we;
    logic [31:0] obs_addr;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata;
    int          n_stall, n_req, n_err, n_mis;
    logic        first_stall, fields_stable, hung;

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00: case (a)
                2'd0: return 4'b0001;
                2'd1: return 4'b0010;
                2'd2: return 4'b0100;
                default: return 4'b1000;
            endcase
            2'b01: return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00: return {d[7:0], d[7:0], d[7:0], d[7:0]};
            2'b01: return {d[15:0], d[15:0]};
            default: return d;
        endcase
    endfunction

    // Drives one access from a negedge, plays the bus slave, and records what the DUT did.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] data,
                              input int ack_cyc, input logic [31:0] rdata, input int flush_cyc);
        int   busy_idx;
        logic saw;
        busy_idx = 0; saw = 1'b0; n_stall = 0; n_req = 0; n_err = 0; n_mis = 0;
        fields_stable = 1'b1; hung = 1'b1;
        mem_rd = rd; mem_wr = wr; func3 = f3; alu_out = addr; rs2_data = data;
        flush = 1'b0; dbus_ack = 1'b0;
        #1;
        first_stall = stall;
        if (stall) n_stall++;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            dbus_ack = 1'b0;
            flush    = 1'b0;
            if (bus_err)  n_err++;
            if (misalign) n_mis++;
            if (dbus_req) begin
                n_req++;
                busy_idx++;
                if (!saw) begin
                    obs_we = dbus_we; obs_addr = dbus_addr; obs_be = dbus_be; obs_wdata = dbus_wdata;
                    saw = 1'b1;
                end else if ({dbus_we, dbus_addr, dbus_be, dbus_wdata} !==
                             {obs_we, obs_addr, obs_be, obs_wdata}) begin
                    fields_stable = 1'b0;
                end
            end
            if (!stall && (saw || n_mis != 0)) begin
                hung = 1'b0;
                break;
            end
            if (stall) n_stall++;
            if (dbus_req) begin
                if (busy_idx == ack_cyc) begin
                    dbus_ack = 1'b1; dbus_rdata = rdata;
                end
                if (busy_idx == flush_cyc) begin
                    flush = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0;
                end
            end
        end
        mem_rd = 1'b0; mem_wr = 1'b0; flush = 1'b0; dbus_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_rd = 1'b1; func3 = 3'b010; alu_out = 32'h100;
        @(negedge clk);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if ({dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata} !== 70'h0) begin
            errors++; $display("FAIL reset_bus: req=%b we=%b addr=%h be=%b wdata=%h want all 0",
                               dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata); end
        checks++; if ({dm_out, bus_err, misalign} !== 34'h0) begin
            errors++; $display("FAIL reset_out: dm=%h err=%b mis=%b want 0", dm_out, bus_err, misalign); end
        mem_rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_dm = 32'h0;
    endtask

    task automatic test_load_byte();
        exp_t e;
        @(negedge clk);
        exp_q.push_back('{we:1'b0, addr:32'h1000, be:4'b1000, wdata:32'h0, chk_wdata:1'b0,
                          dm:32'h0000_00AA, stalls:3, reqs:2, errs:0});
        run_access(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 2, 32'hAABB_CCDD, 0);
        e = exp_q.pop_front();
        model_dm = e.dm;
        checks++; if (hung !== 1'b0) begin errors++; $display("FAIL lb_done: access never completed"); end
        checks++; if ({obs_we, obs_addr, obs_be} !== {e.we, e.addr, e.be}) begin errors++;
            $display("FAIL lb_bus: we=%b addr=%h be=%b want we=%b addr=%h be=%b", obs_we, obs_addr, obs_be, e.we, e.addr, e.be); end
        checks++; if (dm_out !== e.dm) begin errors++; $display("FAIL lb_dm: got %h want %h", dm_out, e.dm); end
        checks++; if (n_stall != e.stalls) begin errors++; $display("FAIL lb_stall: got %0d want %0d", n_stall, e.stalls); end
        checks++; if (n_req != e.reqs) begin errors++; $display("FAIL lb_req: got %0d want %0d", n_req, e.reqs); end
        checks++; if (fields_stable !== 1'b1) begin errors++; $display("FAIL lb_stable: bus fields changed while req=1"); end
        checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL lb_req_drop: got %b want 0", dbus_req); end
    endtask

    task automatic test_store_half();
        exp_t e;
        @(negedge clk);
        exp_q.push_back('{we:1'b1, addr:32'h2000, be:4'b1100, wdata:32'hABCD_ABCD, chk_wdata:1'b1,
                          dm:model_dm, stalls:2, reqs:1, errs:0});
        run_access(1'b0, 1'b1, 3'b001, 32'h2002, 32'h1234_ABCD, 1, 32'h5555_5555, 0);
        e = exp_q.pop_front();
        checks++; if ({obs_we, obs_addr, obs_be, obs_wdata} !== {e.we, e.addr, e.be, e.wdata}) begin errors++;
            $display("FAIL sh_bus: we=%b addr=%h be=%b wdata=%h want we=%b addr=%h be=%b wdata=%h",
                     obs_we, obs_addr, obs_be, obs_wdata, e.we, e.addr, e.be, e.wdata); end
        checks++; if (dm_out !== e.dm) begin errors++; $display("FAIL sh_dm: got %h want %h", dm_out, e.dm); end
        checks++; if (n_stall != e.stalls) begin errors++; $display("FAIL sh_stall: got %0d want %0d", n_stall, e.stalls); end
    endtask

    task automatic test_lanes();
        exp_t        e;
        logic [31:0] d;
        logic [2:0]  f3;
        for (int w = 0; w < 3; w++) begin
            for (int a = 0; a < 4; a++) begin
                @(negedge clk);
                f3 = 3'(w);
                d  = $urandom;
                exp_q.push_back('{we:1'b1, addr:32'h4000, be:ref_be(f3, 2'(a)), wdata:ref_wdata(f3, d),
                                  chk_wdata:1'b1, dm:model_dm, stalls:2, reqs:1, errs:0});
                run_access(1'b0, 1'b1, f3, 32'h4000 + 32'(a), d, 1, 32'h0, 0);
                e = exp_q.pop_front();
                checks++; if ({obs_we, obs_addr, obs_be, obs_wdata} !== {e.we, e.addr, e.be, e.wdata}) begin errors++;
                    $display("FAIL st_lane f3=%0d a=%0d: we=%b addr=%h be=%b wdata=%h want we=%b addr=%h be=%b wdata=%h",
                             w, a, obs_we, obs_addr, obs_be, obs_wdata, e.we, e.addr, e.be, e.wdata); end
                checks++; if (dm_out !== e.dm) begin errors++; $display("FAIL st_dm f3=%0d a=%0d: got %h want %h", w, a, dm_out, e.dm); end
            end
        end
        for (int a = 0; a < 4; a++) begin
            @(negedge clk);
            d = $urandom;
            exp_q.push_back('{we:1'b0, addr:32'h4400, be:ref_be(3'b000, 2'(a)), wdata:32'h0, chk_wdata:1'b0,
                              dm:d >> (8 * a), stalls:2, reqs:1, errs:0});
            run_access(1'b1, 1'b0, 3'b100, 32'h4400 + 32'(a), 32'h0, 1, d, 0);
            e = exp_q.pop_front();
            model_dm = e.dm;
            checks++; if (obs_be !== e.be) begin errors++; $display("FAIL ld_be a=%0d: got %b want %b", a, obs_be, e.be); end
            checks++; if (dm_out !== e.dm) begin errors++; $display("FAIL ld_dm a=%0d: got %h want %h", a, dm_out, e.dm); end
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        @(negedge clk);
        exp_q.push_back('{we:1'b0, addr:32'h7000, be:4'b1111, wdata:32'h0, chk_wdata:1'b0,
                          dm:32'h0, stalls:5, reqs:4, errs:1});
        run_access(1'b1, 1'b0, 3'b010, 32'h7000, 32'h0, 0, 32'h0, 0);
        e = exp_q.pop_front();
        model_dm = e.dm;
        checks++; if (hung !== 1'b0) begin errors++; $display("FAIL to_done: abort never reached DONE"); end
        checks++; if (n_req != e.reqs) begin errors++; $display("FAIL to_req: got %0d want %0d", n_req, e.reqs); end
        checks++; if (n_err != e.errs) begin errors++; $display("FAIL to_err: got %0d want %0d", n_err, e.errs); end
        checks++; if (dm_out !== e.dm) begin errors++; $display("FAIL to_dm: got %h want %h", dm_out, e.dm); end
        checks++; if (n_stall != e.stalls) begin errors++; $display("FAIL to_stall: got %0d want %0d", n_stall, e.stalls); end
        @(negedge clk);
        checks++; if ({bus_err, stall} !== 2'b00) begin errors++; $display("FAIL to_pulse: err=%b stall=%b want 0 0", bus_err, stall); end
    endtask

    task automatic test_flush();
        exp_t e;
        @(negedge clk);
        run_access(1'b1, 1'b0, 3'b010, 32'h6000, 32'h0, 1, 32'hDEAD_BEEF, 0);
        model_dm = 32'hDEAD_BEEF;
        checks++; if (dm_out !== model_dm) begin errors++; $display("FAIL fl_pre: got %h want %h", dm_out, model_dm); end
        @(negedge clk);
        exp_q.push_back('{we:1'b0, addr:32'h6000, be:4'b1111, wdata:32'h0, chk_wdata:1'b0,
                          dm:model_dm, stalls:4, reqs:3, errs:0});
        run_access(1'b1, 1'b0, 3'b010, 32'h6000, 32'h0, 3, 32'h9999_9999, 1);
        e = exp_q.pop_front();
        checks++; if (dm_out !== e.dm) begin errors++; $display("FAIL fl_dm: got %h want %h", dm_out, e.dm); end
        checks++; if (n_req != e.reqs) begin errors++; $display("FAIL fl_req: got %0d want %0d", n_req, e.reqs); end
        checks++; if (n_stall != e.stalls) begin errors++; $display("FAIL fl_stall: got %0d want %0d", n_stall, e.stalls); end
        // Straight back to IDLE: the next access must be accepted with no DONE cycle in between.
        exp_q.push_back('{we:1'b0, addr:32'h6000, be:4'b0010, wdata:32'h0, chk_wdata:1'b0,
                          dm:32'h0055_6677, stalls:2, reqs:1, errs:0});
        run_access(1'b1, 1'b0, 3'b000, 32'h6001, 32'h0, 1, 32'h5566_7788, 0);
        e = exp_q.pop_front();
        model_dm = e.dm;
        checks++; if (first_stall !== 1'b1) begin errors++; $display("FAIL fl_nodone: first stall=%b want 1", first_stall); end
        checks++; if (dm_out !== e.dm) begin errors++; $display("FAIL fl_next_dm: got %h want %h", dm_out, e.dm); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        @(negedge clk);
        run_access(1'b1, 1'b0, 3'b010, 32'h5000, 32'h0, 1, 32'h0102_0304, 0);
        exp_q.push_back('{we:1'b0, addr:32'h5000, be:4'b1100, wdata:32'h0, chk_wdata:1'b0,
                          dm:32'h0000_CAFE, stalls:2, reqs:1, errs:0});
        run_access(1'b1, 1'b0, 3'b001, 32'h5002, 32'h0, 1, 32'hCAFE_F00D, 0);
        e = exp_q.pop_front();
        model_dm = e.dm;
        checks++; if (first_stall !== 1'b0) begin errors++; $display("FAIL b2b_done_stall: got %b want 0", first_stall); end
        checks++; if (obs_be !== e.be) begin errors++; $display("FAIL b2b_be: got %b want %b", obs_be, e.be); end
        checks++; if (dm_out !== e.dm) begin errors++; $display("FAIL b2b_dm: got %h want %h", dm_out, e.dm); end
        checks++; if (n_stall != e.stalls) begin errors++; $display("FAIL b2b_stall: got %0d want %0d", n_stall, e.stalls); end
    endtask

    task automatic test_idle_cases();
        @(negedge clk);
        mem_rd = 1'b1; func3 = 3'b010; alu_out = 32'h9000; flush = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL idle_flush_stall: got %b want 0", stall); end
        @(negedge clk);
        checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL idle_flush_req: got %b want 0", dbus_req); end
        mem_rd = 1'b0; flush = 1'b0; dbus_ack = 1'b1; dbus_rdata = 32'h7777_7777;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nonmem_stall: got %b want 0", stall); end
        @(negedge clk);
        dbus_ack = 1'b0;
        checks++; if ({dbus_req, dm_out} !== {1'b0, model_dm}) begin errors++;
            $display("FAIL idle_ack: req=%b dm=%h want 0 %h", dbus_req, dm_out, model_dm); end
    endtask

    task automatic test_misalign();
        exp_t e;
        @(negedge clk);
`ifdef LSU_MISALIGN_CHK_EN
        exp_q.push_back('{we:1'b0, addr:32'h1000, be:4'b1111, wdata:32'h0, chk_wdata:1'b0,
                          dm:32'h0, stalls:1, reqs:0, errs:0});
        run_access(1'b1, 1'b0, 3'b010, 32'h1002, 32'h0, 1, 32'hAABB_CCDD, 0);
        e = exp_q.pop_front();
        checks++; if (n_req != e.reqs) begin errors++; $display("FAIL mis_req: got %0d want %0d", n_req, e.reqs); end
        checks++; if (n_mis != 1) begin errors++; $display("FAIL mis_pulse: got %0d want 1", n_mis); end
        checks++; if (first_stall !== 1'b1) begin errors++; $display("FAIL mis_stall: got %b want 1", first_stall); end
        @(negedge clk);
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_width: got %b want 0", misalign); end
`else
        exp_q.push_back('{we:1'b0, addr:32'h1000, be:4'b1111, wdata:32'h0, chk_wdata:1'b0,
                          dm:32'h0000_AABB, stalls:2, reqs:1, errs:0});
        run_access(1'b1, 1'b0, 3'b010, 32'h1002, 32'h0, 1, 32'hAABB_CCDD, 0);
        e = exp_q.pop_front();
        checks++; if ({obs_addr, obs_be} !== {e.addr, e.be}) begin errors++;
            $display("FAIL mis_off_bus: addr=%h be=%b want addr=%h be=%b", obs_addr, obs_be, e.addr, e.be); end
        checks++; if (n_mis != 0) begin errors++; $display("FAIL mis_off_pulse: got %0d want 0", n_mis); end
`endif
        model_dm = e.dm;
        checks++; if (dm_out !== e.dm) begin errors++; $display("FAIL mis_dm: got %h want %h", dm_out, e.dm); end
    endtask

    task automatic test_reset_mid_busy();
        exp_t e;
        @(negedge clk);
        mem_rd = 1'b1; func3 = 3'b010; alu_out = 32'h8000;
        @(negedge clk);
        checks++; if (dbus_req !== 1'b1) begin errors++; $display("FAIL rb_req: got %b want 1", dbus_req); end
        rst = 1'b1;
        #1;
        checks++; if ({dbus_req, stall} !== 2'b00) begin errors++; $display("FAIL rb_async: req=%b stall=%b want 0 0", dbus_req, stall); end
        @(negedge clk);
        rst = 1'b0; mem_rd = 1'b0; dbus_ack = 1'b1; dbus_rdata = 32'h1234_5678;
        @(negedge clk);
        dbus_ack = 1'b0;
        model_dm = 32'h0;
        checks++; if ({dbus_req, stall, bus_err, dm_out} !== 35'h0) begin errors++;
            $display("FAIL rb_late_ack: req=%b stall=%b err=%b dm=%h want all 0", dbus_req, stall, bus_err, dm_out); end
        exp_q.push_back('{we:1'b0, addr:32'h8000, be:4'b0001, wdata:32'h0, chk_wdata:1'b0,
                          dm:32'h0000_00EE, stalls:2, reqs:1, errs:0});
        run_access(1'b1, 1'b0, 3'b000, 32'h8000, 32'h0, 1, 32'h0000_00EE, 0);
        e = exp_q.pop_front();
        checks++; if (dm_out !== e.dm) begin errors++; $display("FAIL rb_recover: got %h want %h", dm_out, e.dm); end
    endtask

    initial begin
        rst = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; func3 = 3'b000; alu_out = 32'h0;
        rs2_data = 32'h0; flush = 1'b0; dbus_ack = 1'b0; dbus_rdata = 32'h0; model_dm = 32'h0;
        test_reset();
        test_load_byte();
        test_store_half();
        test_lanes();
        test_timeout();
        test_flush();
        test_back_to_back();
        test_idle_cases();
        test_misalign();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/mem_lsu_stage.md
Name: mem_lsu_stage

Overview:
- Memory-stage load/store unit between the execute/memory pipeline register and the memory/writeback pipeline register.
- Turns a load or store from the memory stage into a single request/acknowledge transaction on the data-memory bus.
- Generates byte lanes and store-data replication, and stalls the pipeline until the access completes.
- Delivers the lane-aligned load word on dm_out; sign/zero extension by func3 happens downstream in writeback.

Parameters:
- TIMEOUT, 16, max cycles to wait for dbus_ack in BUSY before aborting; 0 = wait forever.
- TO_W, 16, width of the timeout counter; TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_rd  in  1  load in memory stage.
- mem_wr  in  1  store in memory stage; mem_rd and mem_wr are never both 1.
- func3  in  3  RISC-V width code; [1:0]: 00 byte, 01 half, 10 word.
- alu_out  in  32  effective byte address.
- rs2_data  in  32  store source data.
- flush  in  1  kill the current memory-stage instruction.
- stall  out  1  freeze upstream stages and hold the M/W register input.
- dm_out  out  32  load result, registered, shifted right by 8*alu_out[1:0].
- bus_err  out  1  one-cycle pulse: timeout abort.
- misalign  out  1  one-cycle pulse: misaligned access (feature only; tied 0 otherwise).
- dbus_req  out  1  bus request, registered.
- dbus_we  out  1  1 = write, registered.
- dbus_addr  out  32  word address {alu_out[31:2],2'b00}, registered.
- dbus_be  out  4  byte enables, registered.
- dbus_wdata  out  32  replicated store data, registered.
- dbus_ack  in  1  transaction complete; sampled only while dbus_req=1.
- dbus_rdata  in  32  read data, valid with dbus_ack on loads.

Behaviour:
- Reset (rst=1, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including dbus_req, which drops immediately even mid-transaction.
  - Timeout counter is cleared.
- States: IDLE, BUSY, DONE.
- stall is combinational: 1 when (IDLE and (mem_rd|mem_wr) and !flush) or BUSY; 0 otherwise.
- IDLE:
  - Access (mem_rd|mem_wr) with !flush: register the bus fields, set dbus_req=1, go to BUSY, clear the counter.
  - flush=1: no request is issued and the state stays IDLE.
  - dbus_ack is ignored in IDLE.
- Byte lanes, with a = alu_out[1:0]:
  - Byte: be = 4'b0001<<a, wdata = {4{rs2_data[7:0]}}.
  - Half: be = 4'b0011<<(2*a[1]), wdata = {2{rs2_data[15:0]}}.
  - Word or func3[1:0]=11: be = 4'b1111, wdata = rs2_data.
  - Loads use the same be value.
- BUSY:
  - dbus_* fields are held stable while dbus_req=1.
  - On dbus_ack: dbus_req drops to 0 on the same edge.
    - Load: dm_out <= dbus_rdata >> (8*a).
    - Store: dm_out is unchanged.
    - Next state is DONE.
  - No ack: the counter increments. If TIMEOUT≠0 and the counter reaches TIMEOUT-1 without ack: drop dbus_req, pulse bus_err, dm_out <= 0, go to DONE.
  - flush while BUSY: the bus transaction still completes (it cannot be abandoned), but the result is discarded. dm_out is not updated, and the state goes to IDLE instead of DONE. A flush seen at any cycle of BUSY is remembered.
- DONE:
  - stall=0, so the M/W register captures dm_out on this cycle.
  - Unconditionally go to IDLE next cycle.
  - Minimum access is 3 cycles: IDLE-request, BUSY-with-ack, DONE.
- Back-to-back accesses: a new access is accepted only in IDLE; at least 1 idle-state cycle separates transactions.
- a is latched with the request so the dm_out shift uses the registered offset.
- Non-memory instructions pass through in 1 cycle with stall=0; dm_out holds its last value.

Optional Feature:
- Macro: LSU_MISALIGN_CHK_EN.
- Enabled:
  - In IDLE, a half access with alu_out[0]=1 or a word access with alu_out[1:0]≠0 issues no bus request.
  - misalign pulses 1 cycle, dm_out <= 0, and the state goes directly to DONE (stall=1 for the IDLE cycle).
- Disabled: misalign is tied 0 and misaligned accesses are issued using the lane rules above (low address bits truncated).

Test Plan:
- Load byte, alu_out=0x1003, rdata=0xAABBCCDD, ack after 2 BUSY cycles -> dbus_addr=0x1000, be=1000, dm_out=0x000000AA, stall high for 3 cycles, then DONE.
- Store half, alu_out=0x2002, rs2=0x1234ABCD, ack in the first BUSY cycle -> be=1100, wdata=0xABCDABCD, we=1, dm_out unchanged.
- TIMEOUT=4 load with no ack -> dbus_req high for 4 cycles, bus_err single pulse, dm_out=0, back to IDLE after DONE.
- flush asserted in BUSY cycle 1, ack in cycle 3 -> dm_out keeps its prior value, no DONE state, stall falls after ack.
- rst pulsed mid-BUSY -> dbus_req=0 and stall=0 immediately; a late ack after reset has no effect.
- With LSU_MISALIGN_CHK_EN, word load at 0x1002 -> no dbus_req, misalign pulse, dm_out=0; without it, dbus_addr=0x1000, be=1111.
